// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte queue and frame pacer sitting directly in front of the UART
//   transmitter. Words written from the system side are buffered in a small
//   circular queue. They are handed to TX one at a time as one-cycle OE pulses.
//   TX has no busy output, so consecutive pulses are spaced a full frame slot
//   apart, which means a frame is never cut short.
//
// Ports
//   CLK    in   1               system clock, rising edge
//   RST_N  in   1               asynchronous active-low reset
//   DIN    in   Wdata           word to enqueue
//   WE     in   1               enqueue strobe
//   FULL   out  1               queue holds Depth words
//   EMPTY  out  1               queue holds no words
//   LEVEL  out  clog2(Depth)+1  words currently queued
//   OVF    out  1               one-cycle pulse: WE while FULL, word dropped
//   DOUT   out  Wdata           word presented to TX, valid while OE=1
//   OE     out  1               one-cycle load strobe to TX
//
// Handshake: a word is taken on any rising edge where WE=1 and FULL=0.
//   WE with FULL=1 drops the word and raises OVF for the following cycle.
//   On the TX side, DOUT is meaningful only in the cycle where OE=1. TX
//   gives no back-pressure.
module uart_tx_queue #(
    parameter int Fclk  = 12000000,
    parameter int Bauds = 115200,
    parameter int Wdata = 8,
    parameter int Wstop = 1,
    parameter int Depth = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [Wdata-1:0]         DIN,
    input  logic                     WE,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(Depth):0]   LEVEL,
    output logic                     OVF,
    output logic [Wdata-1:0]         DOUT,
    output logic                     OE
);

    localparam int Nticks = Fclk / Bauds;
    localparam int Wframe = 1 + Wdata + Wstop;
    localparam int Slot   = Wframe * (Nticks + 1) + 1;
    localparam int AW     = $clog2(Depth);
    localparam int CW     = $clog2(Slot);

    localparam logic [CW-1:0] SLOT_M1 = CW'(Slot - 1);
    localparam logic [CW-1:0] SLOT_M2 = CW'(Slot - 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(Depth);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [Wdata-1:0] mem [Depth];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            push;
    logic            pop;
    logic [AW:0]     level_nxt;

    // FULL is the registered flag, so a write in the same cycle as a pop from
    // a full queue is still rejected.
    assign push = WE && !FULL;
    assign pop  = (state == SEND);

    always_comb begin
        level_nxt = LEVEL;
        if (push && !pop) begin
            level_nxt = LEVEL + LVL_ONE;
        end else if (!push && pop) begin
            level_nxt = LEVEL - LVL_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wp] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp    <= '0;
            rp    <= '0;
            LEVEL <= '0;
            FULL  <= 1'b0;
            EMPTY <= 1'b1;
            OVF   <= 1'b0;
        end else begin
            OVF <= WE && FULL;
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            LEVEL <= level_nxt;
            FULL  <= (level_nxt == DEPTH_L);
            EMPTY <= (level_nxt == '0);
        end
    end

    // Pacing FSM. Reset lands in WAIT with a full slot loaded. TX is not
    // reset, so a frame launched just before reset may still be shifting out.
    // WAIT is left on the cycle the counter steps from 1 to 0. This gives one
    // IDLE cycle, and the next SEND lands exactly Slot cycles after the
    // previous one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= WAIT;
            wait_cnt <= SLOT_M1;
            OE       <= 1'b0;
            DOUT     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    OE <= 1'b0;
                    if (!EMPTY) begin
                        state <= SEND;
                        OE    <= 1'b1;
                        DOUT  <= mem[rp];
                    end
                end
                SEND: begin
                    OE       <= 1'b0;
                    wait_cnt <= SLOT_M2;
                    state    <= WAIT;
                end
                WAIT: begin
                    OE <= 1'b0;
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                    if (wait_cnt <= CNT_ONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    OE    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue with Fclk=16, Bauds=4, Wdata=8, Wstop=1, Depth=4.
// With these values a bit lasts 5 cycles, a frame lasts 50 cycles and the slot
// is 51 cycles. A simple TX model consumes OE/DOUT and flags any OE that
// arrives before the previous frame has finished shifting out.
module tb_uart_tx_queue;

    localparam int SLOT  = 51;
    localparam int FRAME = 50;
    localparam int BITC  = 5;

    logic       CLK;
    logic       RST_N;
    logic [7:0] DIN;
    logic       WE;
    logic       FULL;
    logic       EMPTY;
    logic [2:0] LEVEL;
    logic       OVF;
    logic [7:0] DOUT;
    logic       OE;

    uart_tx_queue #(
        .Fclk  (16),
        .Bauds (4),
        .Wdata (8),
        .Wstop (1),
        .Depth (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DIN   (DIN),
        .WE    (WE),
        .FULL  (FULL),
        .EMPTY (EMPTY),
        .LEVEL (LEVEL),
        .OVF   (OVF),
        .DOUT  (DOUT),
        .OE    (OE)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_oe     = 0;
    int         n_ovf    = 0;
    int         last_oe_cyc = 0;
    int         base     = 0;
    bit         gap_check = 1'b0;
    int         tx_busy  = 0;
    logic [9:0] tx_frame = 10'h3ff;
    logic       txd_bit  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - base);
        end
    endtask

    // Monitor and TX model, sampled 1 time unit after the active edge.
    always @(posedge CLK) begin
        #1;
        if (OE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_oe", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("dout", DOUT, e);
            end
            check("tx_trunc", tx_busy, 0);
            if (gap_check && n_oe > 0) begin
                check("oe_gap", cyc - last_oe_cyc, SLOT);
            end
            last_oe_cyc = cyc;
            n_oe++;
            tx_frame = {1'b1, DOUT, 1'b0};
            tx_busy  = FRAME;
        end else if (tx_busy > 0) begin
            tx_busy--;
        end
        txd_bit = (tx_busy == 0) ? 1'b1 : tx_frame[(FRAME - tx_busy) / BITC];
        if (OVF === 1'b1) n_ovf++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int rel);
        while ((cyc - base) < rel) @(negedge CLK);
    endtask

    task automatic send_word(input logic [7:0] d, input bit accept);
        WE  = 1'b1;
        DIN = d;
        if (accept) exp_q.push_back(d);
        @(negedge CLK);
        WE  = 1'b0;
    endtask

    task automatic wait_sent(input int target, input int budget);
        int k;
        k = 0;
        while (n_oe < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("oe_count", n_oe, target);
    endtask

    task automatic wait_oe(input int budget);
        int k;
        k = 0;
        while (OE !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("oe_seen", OE, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] pat;
    logic [7:0] w;
    int         ovf0;
    int         wr_rel;

    initial begin
        RST_N = 1'b0;
        WE    = 1'b0;
        DIN   = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_level", LEVEL, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_full",  FULL, 0);
        check("rst_ovf",   OVF, 0);
        check("rst_oe",    OE, 0);
        check("rst_dout",  DOUT, 0);
        RST_N = 1'b1;
        base  = cyc;

        // Test 1: single word, latency and line pattern.
        wait_until(60);
        send_word(8'hA5, 1'b1);
        check("t1_level1", LEVEL, 1);
        wait_sent(1, 20);
        check("t1_oe_cycle", last_oe_cyc - base, 62);
        wait_until(63);
        check("t1_level0", LEVEL, 0);
        check("t1_empty", EMPTY, 1);
        pat = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            wait_until(64 + BITC * i);
            check("t1_txd", txd_bit, pat[i]);
        end

        // Test 2/3: burst to full, overflow while full and during SEND.
        wait_until(120);
        send_word(8'h10, 1'b1);
        wait_sent(2, 20);
        check("t2_oe_cycle", last_oe_cyc - base, 122);
        wait_until(130);
        gap_check = 1'b1;
        for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b1);
        check("t2_level4", LEVEL, 4);
        check("t2_full", FULL, 1);
        wait_until(140);
        ovf0 = n_ovf;
        send_word(8'h55, 1'b0);
        check("t3_ovf_hi", OVF, 1);
        @(negedge CLK);
        check("t3_ovf_lo", OVF, 0);
        check("t3_level", LEVEL, 4);
        check("t3_ovf_cnt", n_ovf - ovf0, 1);
        wait_oe(100);
        check("t3_send_cycle", cyc - base, 173);
        check("t3_full_at_send", FULL, 1);
        send_word(8'h55, 1'b0);
        check("t3_ovf_send", OVF, 1);
        check("t3_level_send", LEVEL, 3);
        wait_sent(6, 300);
        check("t2_last_oe", last_oe_cyc - base, 122 + 4 * SLOT);
        wait_until(327);
        check("t2_empty", EMPTY, 1);
        check("t2_level0", LEVEL, 0);
        gap_check = 1'b0;

        // Test 4: paced writes, pointers wrap.
        for (int i = 0; i < 6; i++) begin
            wr_rel = 380 + 60 * i;
            wait_until(wr_rel);
            w = 8'($urandom_range(0, 255));
            send_word(w, 1'b1);
            wait_sent(7 + i, 10);
            check("t4_latency", last_oe_cyc - base - wr_rel, 2);
        end

        // Test 6: push coinciding with SEND at LEVEL=2.
        wait_until(700);
        send_word(8'($urandom_range(0, 255)), 1'b1);
        send_word(8'($urandom_range(0, 255)), 1'b1);
        check("t6_level2", LEVEL, 2);
        wait_oe(100);
        check("t6_level_send", LEVEL, 2);
        send_word(8'hC3, 1'b1);
        check("t6_level_after", LEVEL, 2);
        wait_sent(15, 200);

        // Test 5: reset during WAIT; post-reset slot must be honoured.
        wait_until(900);
        send_word(8'h3C, 1'b1);
        send_word(8'h77, 1'b1);
        wait_sent(16, 10);
        wait_until(905);
        RST_N = 1'b0;
        #1;
        check("t5_oe", OE, 0);
        check("t5_level", LEVEL, 0);
        check("t5_empty", EMPTY, 1);
        exp_q.delete();
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        base  = cyc;
        send_word(8'h9E, 1'b1);
        wait_sent(17, 120);
        check("t5_post_rst_wait", (last_oe_cyc - base) >= SLOT, 1);

        // Final: nothing stray left or sent.
        repeat (60) @(negedge CLK);
        check("final_oe_total", n_oe, 17);
        check("final_exp_q", exp_q.size(), 0);
        check("final_ovf_total", n_ovf, 2);
        check("final_empty", EMPTY, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
